sync_updown_counter: RTL and testbench

//   Parametrised synchronous modulo-N up/down counter. It succeeds the fixed 4-bit up-only counter.

---
 rtl/sync_updown_counter_pkg.sv | 14 +
 rtl/sync_updown_counter_next_state.sv | 67 ++++++
 rtl/sync_updown_counter.sv | 75 +++++++
 tb/tb_sync_updown_counter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_updown_counter_pkg.sv
// Shared definitions for the counter family.
//   DIR_UP / DIR_DOWN : encodings of the direction input
//   max_val()         : largest count value for a given modulus
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Modulus is carried as longint so that MODULO = 2**32 is representable.
  function automatic longint max_val(input longint modulo);
    return modulo - 1;
  endfunction

endpackage

// File: rtl/sync_updown_counter_next_state.sv
// counter_next_state: combinational next-count logic for sync_updown_counter.
// Build option: SYNC_UPDOWN_COUNTER_SATURATE_EN selects saturation instead of
// modulo wrap at the count limits.
// Ports:
//   q            in   WIDTH  current count
//   en           in   1      count enable
//   up           in   1      direction (DIR_UP / DIR_DOWN)
//   load         in   1      parallel load, highest priority
//   load_val     in   WIDTH  value to load (clamped to MODULO-1)
//   q_next       out  WIDTH  count to register on the next edge
//   hit_terminal out  1      this edge steps past a limit (terminal count)
module counter_next_state
  import counter_pkg::*;
#(
  parameter int     WIDTH  = 4,
  parameter longint MODULO = longint'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_next,
  output logic             hit_terminal
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_val(MODULO));
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic w_at_top;
  logic w_at_bottom;

  assign w_at_top    = (q == MAX_Q);
  assign w_at_bottom = (q == '0);

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next       = q;
    hit_terminal = 1'b0;
    if (load) begin
      // load_val > MAX_Q is the same test as load_val >= MODULO, kept WIDTH bits wide.
      q_next = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (en) begin
      case (up)
        DIR_UP: begin
          hit_terminal = w_at_top;
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
          q_next = w_at_top ? MAX_Q : q + ONE;
`else
          q_next = w_at_top ? '0 : q + ONE;
`endif
        end
        DIR_DOWN: begin
          hit_terminal = w_at_bottom;
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
          q_next = w_at_bottom ? '0 : q - ONE;
`else
          q_next = w_at_bottom ? MAX_Q : q - ONE;
`endif
        end
        default: q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: parametrised synchronous modulo-N up/down counter with
// count enable, direction select, parallel load, combinational terminal count
// for cascading and a registered wrap pulse.
// Build option: SYNC_UPDOWN_COUNTER_SATURATE_EN makes the counter saturate at
// 0 / MODULO-1 instead of wrapping (wrap still pulses on each blocked step).
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active-high
//   en        in   1      count enable
//   up        in   1      1 = increment, 0 = decrement
//   load      in   1      synchronous parallel load (priority over en)
//   load_val  in   WIDTH  value to load
//   q         out  WIDTH  registered count
//   tc        out  1      terminal count, combinational; next stage's enable
//   wrap      out  1      registered one-cycle pulse after a terminal step
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH  = 4,
  parameter longint MODULO = longint'(1) << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be within 1..32");
  end

  if (max_val(MODULO) < 1 || MODULO > (longint'(1) << WIDTH)) begin : g_bad_modulo
    $error("sync_updown_counter: MODULO must be within 2..2**WIDTH");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_hit_terminal;

  counter_next_state #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next_state (
    .q            (r_q),
    .en           (en),
    .up           (up),
    .load         (load),
    .load_val     (load_val),
    .q_next       (w_q_next),
    .hit_terminal (w_hit_terminal)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_hit_terminal;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = w_hit_terminal;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter: directed vector table,
// hand-written multi-cycle sequences, a two-stage cascade and randomized
// stimulus checked against an arithmetic reference model.
module tb_sync_updown_counter;

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MODULO=10
  logic       a_en, a_up, a_load;
  logic [3:0] a_lv, a_q;
  logic       a_tc, a_wrap;

  // Instance B: WIDTH=1, MODULO=2
  logic       b_en, b_up, b_load;
  logic [0:0] b_lv, b_q;
  logic       b_tc, b_wrap;

  // Cascade: two WIDTH=4, MODULO=16 stages
  logic       c_en, c_up, c_load;
  logic [3:0] c_lv, lo_q, hi_q;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

  sync_updown_counter #(.WIDTH(4), .MODULO(10)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
    .q(a_q), .tc(a_tc), .wrap(a_wrap));

  sync_updown_counter #(.WIDTH(1), .MODULO(2)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .q(b_q), .tc(b_tc), .wrap(b_wrap));

  sync_updown_counter #(.WIDTH(4), .MODULO(16)) dut_lo (
    .clk(clk), .rst(rst), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap));

  sync_updown_counter #(.WIDTH(4), .MODULO(16)) dut_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up(c_up), .load(c_load), .load_val(c_lv),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one clock edge of a modulo-m counter, plain arithmetic.
  function automatic void model_step(input int m, input int q, input bit en, input bit up,
                                     input bit load, input int lv,
                                     output int nq, output bit nw);
    nq = q;
    nw = 1'b0;
    if (load) begin
      nq = (lv >= m) ? m - 1 : lv;
    end else if (en && up) begin
      if (q + 1 == m) begin
        nw = 1'b1;
        nq = SAT ? m - 1 : 0;
      end else begin
        nq = q + 1;
      end
    end else if (en) begin
      if (q == 0) begin
        nw = 1'b1;
        nq = SAT ? 0 : m - 1;
      end else begin
        nq = q - 1;
      end
    end
  endfunction

  function automatic bit model_tc(input int m, input int q, input bit en, input bit up,
                                  input bit load);
    return en && !load && (up ? (q == m - 1) : (q == 0));
  endfunction

  typedef struct {
    logic en;
    logic up;
    logic load;
    int   lv;
    logic tc;
    int   q;
    logic wrap;
  } vec_t;

  vec_t vecs[14];

  task automatic set_a(input bit en, input bit up, input bit load, input int lv);
    a_en   = en;
    a_up   = up;
    a_load = load;
    a_lv   = 4'(lv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_q;
    int m_a, m_b, nq;
    bit nw;
    int hi_wraps;

    // Starting from reset (q=0), these rows behave the same in both build modes.
    vecs[0]  = '{1'b1, 1'b1, 1'b0,  0, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1,  7, 1'b0, 7, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0,  0, 1'b0, 7, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0,  0, 1'b0, 6, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 12, 1'b0, 9, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 15, 1'b0, 9, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0,  0, 1'b0, 8, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1,  0, 1'b0, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, 0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1,  9, 1'b0, 9, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0,  0, 1'b0, 9, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1,  1, 1'b0, 1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0,  0, 1'b0, 0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1,  9, 1'b0, 9, 1'b0};

    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 0);
    b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_lv = 1'b0;
    c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_lv = 4'd0;

    // Reset state
    repeat (2) tick();
    check("reset_q", a_q, 0);
    check("reset_wrap", a_wrap, 0);
    check("reset_tc", a_tc, 0);
    check("reset_b_q", b_q, 0);
    check("reset_cascade", {hi_q, lo_q}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors on instance A
    for (int i = 0; i < 14; i++) begin
      set_a(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv);
      #1;
      check($sformatf("vec%0d_tc", i), a_tc, vecs[i].tc);
      tick();
      check($sformatf("vec%0d_q", i), a_q, vecs[i].q);
      check($sformatf("vec%0d_wrap", i), a_wrap, vecs[i].wrap);
    end

    // Reset between edges at q=7 while counting
    set_a(1'b0, 1'b0, 1'b1, 7);
    tick();
    check("midrst_pre_q", a_q, 7);
    set_a(1'b1, 1'b1, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_q", a_q, 0);
    check("midrst_wrap", a_wrap, 0);
    #1 rst = 1'b0;
    tick();
    check("midrst_after_q", a_q, 1);

`ifndef SYNC_UPDOWN_COUNTER_SATURATE_EN
    // Up wrap: 12 edges from 0
    set_a(1'b0, 1'b0, 1'b1, 0);
    tick();
    set_a(1'b1, 1'b1, 1'b0, 0);
    exp_q = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("upwrap%0d_tc", i), a_tc, (exp_q == 9) ? 1 : 0);
      tick();
      exp_q = (exp_q + 1) % 10;
      check($sformatf("upwrap%0d_q", i), a_q, exp_q);
      check($sformatf("upwrap%0d_wrap", i), a_wrap, (exp_q == 0) ? 1 : 0);
    end

    // Down wrap from 1
    set_a(1'b0, 1'b0, 1'b1, 1);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 0);
    #1 check("down_tc0", a_tc, 0);
    tick();
    check("down_q0", a_q, 0);
    check("down_wrap0", a_wrap, 0);
    check("down_tc1", a_tc, 1);
    tick();
    check("down_q1", a_q, 9);
    check("down_wrap1", a_wrap, 1);
    check("down_tc2", a_tc, 0);
    tick();
    check("down_q2", a_q, 8);
    check("down_wrap2", a_wrap, 0);
`else
    // Saturation: up from 8 for three edges, then down at 0
    set_a(1'b0, 1'b0, 1'b1, 8);
    tick();
    set_a(1'b1, 1'b1, 1'b0, 0);
    tick();
    check("sat_q1", a_q, 9);
    check("sat_wrap1", a_wrap, 0);
    check("sat_tc1", a_tc, 1);
    tick();
    check("sat_q2", a_q, 9);
    check("sat_wrap2", a_wrap, 1);
    tick();
    check("sat_q3", a_q, 9);
    check("sat_wrap3", a_wrap, 1);
    set_a(1'b0, 1'b0, 1'b1, 0);
    tick();
    check("sat_wrap_load", a_wrap, 0);
    set_a(1'b1, 1'b0, 1'b0, 0);
    #1 check("sat_down_tc", a_tc, 1);
    tick();
    check("sat_down_q", a_q, 0);
    check("sat_down_wrap", a_wrap, 1);
`endif

    // Load priority with clamp, then a terminal step
    set_a(1'b0, 1'b0, 1'b1, 3);
    tick();
    set_a(1'b1, 1'b1, 1'b1, 12);
    #1 check("loadpri_tc", a_tc, 0);
    tick();
    check("loadpri_q", a_q, 9);
    check("loadpri_wrap", a_wrap, 0);
    a_load = 1'b0;
    #1 check("loadpri_tc_next", a_tc, 1);
    tick();
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
    check("loadpri_q_next", a_q, 9);
`else
    check("loadpri_q_next", a_q, 0);
`endif
    check("loadpri_wrap_next", a_wrap, 1);
    set_a(1'b0, 1'b0, 1'b0, 0);

`ifndef SYNC_UPDOWN_COUNTER_SATURATE_EN
    // Two-stage cascade, 256 edges
    hi_wraps = 0;
    c_en = 1'b1;
    c_up = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (hi_wrap) hi_wraps++;
      check($sformatf("cascade%0d", i), {hi_q, lo_q}, (i + 1) % 256);
    end
    check("cascade_hi_wrap_now", hi_wrap, 1);
    check("cascade_hi_wraps", hi_wraps, 1);
    c_en = 1'b0;
`endif

    // Randomized stimulus against the model, starting from a reset
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    m_a = 0;
    m_b = 0;
    check("rand_start_q", a_q, 0);
    for (int i = 0; i < 500; i++) begin
      set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
      b_en   = $urandom_range(0, 3) != 0;
      b_up   = $urandom_range(0, 1) == 1;
      b_load = $urandom_range(0, 7) == 0;
      b_lv   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_a = 0;
        m_b = 0;
        check($sformatf("rand%0d_rst_q", i), a_q, 0);
        check($sformatf("rand%0d_rst_wrap", i), a_wrap, 0);
        check($sformatf("rand%0d_rst_b_q", i), b_q, 0);
      end
      #1;
      check($sformatf("rand%0d_a_tc", i), a_tc, model_tc(10, m_a, a_en, a_up, a_load));
      check($sformatf("rand%0d_b_tc", i), b_tc, model_tc(2, m_b, b_en, b_up, b_load));
      tick();
      model_step(10, m_a, a_en, a_up, a_load, int'(a_lv), nq, nw);
      m_a = nq;
      check($sformatf("rand%0d_a_q", i), a_q, m_a);
      check($sformatf("rand%0d_a_wrap", i), a_wrap, nw);
      model_step(2, m_b, b_en, b_up, b_load, int'(b_lv), nq, nw);
      m_b = nq;
      check($sformatf("rand%0d_b_q", i), b_q, m_b);
      check($sformatf("rand%0d_b_wrap", i), b_wrap, nw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
